// File: rtl/freq_cnt_pkg.sv
// rtl/freq_cnt_pkg.sv - shared constants and types for the frequency counter BCD datapath
package freq_cnt_pkg;

    localparam int BCD_DIGITS = 6;
    localparam int BCD_MAX    = 999999;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // All-nines pattern shown when the count does not fit in six digits
    localparam logic [BCD_W-1:0] BCD_SAT = {BCD_DIGITS{4'd9}};

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3_adj.sv
// rtl/bcd_add3_adj.sv - double-dabble correction: add 3 to every digit >= 5
// bcd_in  : packed BCD accumulator, digit 0 in bits [3:0]
// bcd_out : corrected accumulator, ready to be shifted left by one
module bcd_add3_adj
    import freq_cnt_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0] bcd_out
);

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        bcd_digit_t digit;
        assign digit = bcd_in[4*i +: 4];
        // Digits entering here are 0..9, so the sum never exceeds 12
        assign bcd_out[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary to six-digit BCD converter, one bit per clock
// clk, rst_n       : clock, asynchronous active-low reset
// start, bin_in    : request and value, sampled when idle or in the done cycle
// *_out digits     : registered result, updated only when done rises
// overflow         : last result saturated to 999999
// busy, done       : conversion in progress / one-cycle completion pulse
module bin_to_bcd_seq #(
    parameter int BIN_W   = 20,
    parameter int BCD_MAX = 999999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [3:0]       hundred_thousands_out,
    output logic [3:0]       ten_thousands_out,
    output logic [3:0]       thousands_out,
    output logic [3:0]       hundreds_out,
    output logic [3:0]       tens_out,
    output logic [3:0]       units_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    import freq_cnt_pkg::BCD_W;
    import freq_cnt_pkg::BCD_SAT;
    import freq_cnt_pkg::state_t;
    import freq_cnt_pkg::ST_IDLE;
    import freq_cnt_pkg::ST_SHIFT;
    import freq_cnt_pkg::ST_DONE;

    localparam int         CNT_W   = $clog2(BIN_W + 1);
    localparam logic [32:0] MAX_EXT = 33'(BCD_MAX);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   acc, acc_adj, acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic [BCD_W-1:0]   res;
    logic               res_ovf;
    logic               accept;
    logic               last_shift;

    // A new request is taken when idle, and also in the done cycle so
    // back-to-back conversions need no idle bubble
    assign accept     = start && (state == ST_IDLE || state == ST_DONE);
    assign last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(BIN_W - 1));

    bcd_add3_adj u_adj (
        .bcd_in  (acc),
        .bcd_out (acc_adj)
    );

    // Shift {accumulator, shreg} left; anything pushed above the six digits
    // is dropped (only reachable for values that saturate anyway)
    assign acc_nxt = BCD_W'({acc_adj, shreg[BIN_W-1]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            res      <= '0;
            res_ovf  <= 1'b0;
        end else if (accept) begin
            shreg    <= bin_in;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= (33'(bin_in) > MAX_EXT);
        end else if (state == ST_SHIFT) begin
            shreg <= BIN_W'({shreg, 1'b0});
            acc   <= acc_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last_shift) begin
                res     <= ovf_pend ? BCD_SAT : acc_nxt;
                res_ovf <= ovf_pend;
            end
        end
    end

    assign hundred_thousands_out = res[23:20];
    assign ten_thousands_out     = res[19:16];
    assign thousands_out         = res[15:12];
    assign hundreds_out          = res[11:8];
    assign tens_out              = res[7:4];
    assign units_out             = res[3:0];
    assign overflow              = res_ovf;
    assign busy                  = (state == ST_SHIFT);
    assign done                  = (state == ST_DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic [3:0]       d5, d4, d3, d2, d1, d0;
    logic             overflow, busy, done;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .BCD_MAX(999999)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .bin_in                (bin_in),
        .hundred_thousands_out (d5),
        .ten_thousands_out     (d4),
        .thousands_out         (d3),
        .hundreds_out          (d2),
        .tens_out              (d1),
        .units_out             (d0),
        .overflow              (overflow),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_bcd();
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    // Decimal digits of a value, saturated to six nines
    function automatic logic [23:0] to_bcd(input longint v);
        logic [23:0] r;
        longint x;
        x = (v > 999999) ? 999999 : v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Transaction-level model: a request is accepted whenever no conversion
    // is in flight; the result appears BIN_W clocks later with a done pulse.
    int          m_left = 0;
    longint      m_val = 0;
    bit          m_done = 1'b0;
    logic [23:0] m_bcd = '0;
    bit          m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_val  = 0;
            m_done = 1'b0;
            m_bcd  = '0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (m_left == 1) begin
                    m_done = 1'b1;
                    m_bcd  = to_bcd(m_val);
                    m_ovf  = (m_val > 999999);
                end
                m_left--;
            end else if (start) begin
                m_val  = longint'(bin_in);
                m_left = BIN_W;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_digits", dut_bcd(), m_bcd);
        chk("cyc_overflow", overflow, m_ovf);
        chk("cyc_busy", busy, (m_left > 0));
        chk("cyc_done", done, m_done);
        for (int i = 0; i < 6; i++) chk("cyc_digit_range", (dut_bcd() >> (4*i)) % 16 <= 9, 1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input longint v);
        start  = 1'b1;
        bin_in = BIN_W'(v);
        cycle();
        start  = 1'b0;
    endtask

    // Called right after the accepting edge; lat counts from the cycle in
    // which start was driven, nbusy counts busy samples until done.
    task automatic wait_done(output int lat, output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while (!done && n < 100) begin
            if (busy) nbusy++;
            cycle();
            n++;
        end
        chk("done_timeout", (n < 100), 1);
        lat = n + 1;
    endtask

    int lat, nb, ndone;
    logic [23:0] seen;

    initial begin
        rst_n = 1'b0;
        repeat (3) cycle();
        chk("reset_digits", dut_bcd(), 24'h000000);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", overflow, 0);
        rst_n = 1'b1;
        cycle();

        // zero
        do_start(0);
        wait_done(lat, nb);
        chk("zero_latency", lat, 21);
        chk("zero_digits", dut_bcd(), 24'h000000);
        chk("zero_ovf", overflow, 0);
        cycle();

        // 123456
        do_start(123456);
        wait_done(lat, nb);
        chk("v123456_busy_cycles", nb, 20);
        chk("v123456_digits", dut_bcd(), 24'h123456);
        chk("v123456_ovf", overflow, 0);
        cycle();

        // saturation boundary
        do_start(999999);
        wait_done(lat, nb);
        chk("v999999_digits", dut_bcd(), 24'h999999);
        chk("v999999_ovf", overflow, 0);
        cycle();
        do_start(1000000);
        wait_done(lat, nb);
        chk("v1000000_latency", lat, 21);
        chk("v1000000_digits", dut_bcd(), 24'h999999);
        chk("v1000000_ovf", overflow, 1);
        cycle();

        // start during busy is ignored
        do_start(345);
        repeat (4) cycle();
        do_start(777);
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                seen = dut_bcd();
            end
            cycle();
        end
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_digits", seen, 24'h000345);
        chk("ignored_start_ovf", overflow, 0);

        // back-to-back: new start in the done cycle
        do_start(42);
        wait_done(lat, nb);
        chk("b2b_first_digits", dut_bcd(), 24'h000042);
        do_start(999);
        chk("b2b_no_idle_busy", busy, 1);
        wait_done(lat, nb);
        chk("b2b_second_latency", lat, 21);
        chk("b2b_second_digits", dut_bcd(), 24'h000999);
        cycle();

        // reset in mid-conversion
        do_start(654321);
        repeat (9) cycle();
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        repeat (2) cycle();
        chk("midrst_digits", dut_bcd(), 24'h000000);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            cycle();
        end
        chk("midrst_no_done", ndone, 0);
        do_start(7);
        wait_done(lat, nb);
        chk("after_rst_latency", lat, 21);
        chk("after_rst_digits", dut_bcd(), 24'h000007);
        cycle();

        // a few extra patterns checked by the per-cycle model
        do_start(99);
        wait_done(lat, nb);
        chk("v99_digits", dut_bcd(), 24'h000099);
        cycle();
        do_start(100000);
        wait_done(lat, nb);
        chk("v100000_digits", dut_bcd(), 24'h100000);
        cycle();
        do_start(1048575);
        wait_done(lat, nb);
        chk("vmax_digits", dut_bcd(), 24'h999999);
        chk("vmax_ovf", overflow, 1);
        repeat (3) cycle();
        chk("hold_digits", dut_bcd(), 24'h999999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter for the frequency counter datapath. It uses shift-and-add-3 (double dabble) and processes one bit per clock. It takes the binary count from the gate counter and produces six BCD digits with a start/done handshake. Output digit ports map one-to-one onto the BCD_Rounding digit inputs, and its done pulse drives BCD_Rounding start.

Parameters:
BIN_W, 20, width of binary input; legal range 4..32
BCD_MAX, 999999, saturation value; largest value six digits can show

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request; captures bin_in
bin_in  input  BIN_W  unsigned binary value to convert
hundred_thousands_out  output  4  BCD digit 10^5
ten_thousands_out  output  4  BCD digit 10^4
thousands_out  output  4  BCD digit 10^3
hundreds_out  output  4  BCD digit 10^2
tens_out  output  4  BCD digit 10^1
units_out  output  4  BCD digit 10^0
overflow  output  1  last result saturated (bin_in > BCD_MAX)
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; outputs valid and updated

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values:
  - all digit outputs 0; overflow 0; busy 0; done 0
  - state IDLE; internal shift and BCD registers 0
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - on start=1, capture bin_in into the shift register and clear the 24-bit BCD accumulator.
  - capture ovf_pend = (bin_in > BCD_MAX) and clear the bit counter.
  - go to SHIFT.
- SHIFT, one cycle per bit, BIN_W cycles total:
  - add 3 to every accumulator digit >= 5.
  - shift {accumulator, shift_reg} left by 1, MSB of bin first.
  - increment the counter; after the BIN_W-th shift go to DONE.
- DONE (one cycle):
  - done=1. Digit outputs and overflow already hold the new result; they are registered on the SHIFT->DONE transition.
  - if start=1 in this cycle, capture a new value and go straight to SHIFT (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- busy is 1 exactly while state=SHIFT.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+BIN_W. For BIN_W=20 that is the cycle following edge k+20. Latency is fixed and independent of data.
- Saturation:
  - if ovf_pend, outputs are 9,9,9,9,9,9 and overflow=1.
  - otherwise outputs are the exact conversion and overflow=0.
  - the conversion still runs the full BIN_W cycles, so latency is unchanged. Accumulator bits above 24 are discarded.
- Output holding: outputs and overflow change only on the SHIFT->DONE edge and hold between conversions.
- start while busy: ignored. No queueing, no effect on the conversion in flight.
- bin_in is only sampled on the accepting edge; it may change afterwards.
- Reset mid-conversion: all state returns to reset values immediately, and no done pulse is issued.
- Each digit output is always in 0..9.

Decomposition:
- Shared package freq_cnt_pkg holds:
  - BCD_DIGITS=6 and BCD_MAX=999999
  - state encoding constants for IDLE/SHIFT/DONE
  - the 4-bit BCD digit typedef (shared with BCD_Rounding)
- One sub-module is natural: bcd_add3_adj. It is purely combinational, applies the >=5 -> +3 correction to all six digits, and is instantiated once in the SHIFT path.

Test Plan:
- bin_in=0, start pulse -> done exactly 21 cycles later; digits 0,0,0,0,0,0; overflow=0.
- bin_in=123456 -> digits 1,2,3,4,5,6; overflow=0; busy high for exactly 20 cycles.
- bin_in=999999 then bin_in=1000000 -> first gives 9,9,9,9,9,9 with overflow=0; second gives 9,9,9,9,9,9 with overflow=1.
- bin_in=345 with start, then start with bin_in=777 during the 5th busy cycle -> single done; digits 0,0,0,3,4,5; second start ignored.
- start with 42; start with 999 asserted in the done cycle -> done pulses 21 cycles apart; results 000042 then 000999; no IDLE cycle between.
- bin_in=654321; deassert rst_n at busy cycle 10 for 2 cycles -> all outputs 0, no done; new start with 7 -> 000007 after 21 cycles.
